// File: rtl/io_bank_pkg.sv
// io_bank_pkg: register offsets and the active-low hex glyph table for pipe_io_bank.
package io_bank_pkg;
  localparam logic [7:0] IN_BASE  = 8'h00;
  localparam logic [7:0] OUT_BASE = 8'h40;
  localparam logic [7:0] STATUS   = 8'h80;
  localparam logic [7:0] HEXCTL   = 8'h84;
  // {g..a}, active low, glyphs 0..F
  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    return GLYPH[v];
  endfunction
endpackage

// File: rtl/io_debounce.sv
// io_debounce: 2-flop synchroniser plus stability counter; chg pulses on the cycle the debounced value updates.
module io_debounce #(
  parameter int W      = 4,
  parameter int DB_CYC = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         chg
);
  localparam int CW = DB_CYC > 1 ? $clog2(DB_CYC) : 1;
  logic [W-1:0] s1_q, s2_q, db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    chg = s2_q != db_q && cnt_q == CW'(DB_CYC - 1);
    db_d = chg ? s2_q : db_q;
    cnt_d = (s2_q == db_q || chg) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
      db_q <= '0;
      cnt_q <= '0;
    end else begin
      s1_q <= din;
      s2_q <= s1_q;
      db_q <= db_d;
      cnt_q <= cnt_d;
    end
  end
  assign dout = db_q;
endmodule

// File: rtl/pipe_io_bank.sv
// pipe_io_bank: memory-mapped I/O bank with debounced inputs, output registers, W1C status/irq
// and a scanned seven-segment display of OUT0.
module pipe_io_bank
  import io_bank_pkg::*;
#(
  parameter int N_IN     = 2,
  parameter int IN_W     = 4,
  parameter int N_OUT    = 3,
  parameter int N_HEX    = 4,
  parameter int DB_CYC   = 16,
  parameter int SCAN_DIV = 1024
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 sel,
  input  logic                 we,
  input  logic [7:0]           addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata,
  input  logic [N_IN*IN_W-1:0] in_ports,
  output logic [N_OUT*32-1:0]  out_ports,
  output logic [6:0]           seg,
  output logic [N_HEX-1:0]     an,
  output logic                 irq
);
  localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int IW = N_HEX > 1 ? $clog2(N_HEX) : 1;
  logic [IN_W-1:0] db [N_IN];
  logic [N_IN-1:0] chg;
  for (genvar i = 0; i < N_IN; i++) begin : g_in
    io_debounce #(.W(IN_W), .DB_CYC(DB_CYC)) u_db (
      .clock(clock),
      .reset(reset),
      .din(in_ports[i*IN_W +: IN_W]),
      .dout(db[i]),
      .chg(chg[i])
    );
  end
  logic [31:0] out_q [N_OUT];
  logic [31:0] out_d [N_OUT];
  logic [N_IN-1:0] status_q, status_d;
  logic [N_HEX-1:0] hexctl_q, hexctl_d, an_q, an_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [6:0] seg_q, seg_d;
  logic irq_q, wr, wrap;
  logic [7:0] a;
  logic [31:0] rd;
  always_comb begin
    wr = sel & we;
    a = {addr[7:2], 2'b00};
    rd = '0;
    for (int i = 0; i < N_IN; i++)
      if (a == IN_BASE + 8'(4 * i)) rd = 32'(db[i]);
    for (int j = 0; j < N_OUT; j++) begin
      out_d[j] = (wr && a == OUT_BASE + 8'(4 * j)) ? wdata : out_q[j];
      if (a == OUT_BASE + 8'(4 * j)) rd = out_q[j];
      out_ports[j*32 +: 32] = out_q[j];
    end
    if (a == STATUS) rd = 32'(status_q);
    if (a == HEXCTL) rd = 32'(hexctl_q);
    rdata = sel ? rd : '0;
    // a change event in the same cycle as a W1C clear keeps the bit set
    status_d = (status_q & ~((wr && a == STATUS) ? wdata[N_IN-1:0] : '0)) | chg;
    hexctl_d = (wr && a == HEXCTL) ? wdata[N_HEX-1:0] : hexctl_q;
    wrap = cnt_q == SW'(SCAN_DIV - 1);
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
    idx_d = !wrap ? idx_q : idx_q == IW'(N_HEX - 1) ? '0 : idx_q + 1'b1;
    an_d = ~(N_HEX'(hexctl_q[idx_q]) << idx_q);
    seg_d = hexctl_q[idx_q] ? hex_glyph(out_q[0][{idx_q, 2'b00} +: 4]) : 7'h7F;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int j = 0; j < N_OUT; j++) out_q[j] <= '0;
      status_q <= '0;
      hexctl_q <= '1;
      cnt_q <= '0;
      idx_q <= '0;
      an_q <= '1;
      seg_q <= 7'h7F;
      irq_q <= 1'b0;
    end else begin
      for (int j = 0; j < N_OUT; j++) out_q[j] <= out_d[j];
      status_q <= status_d;
      hexctl_q <= hexctl_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      an_q <= an_d;
      seg_q <= seg_d;
      irq_q <= |status_q;
    end
  end
  assign an = an_q;
  assign seg = seg_q;
  assign irq = irq_q;
endmodule

// File: tb/tb_pipe_io_bank.sv
// tb_pipe_io_bank: directed checks of pipe_io_bank register map, debounce timing, W1C status, irq and scanning.
module tb_pipe_io_bank;
  localparam int SCAN = 8;
  logic clock = 0, reset = 1, sel = 0, we = 0, irq;
  logic [7:0] addr = 0;
  logic [31:0] wdata = 0, rdata;
  logic [7:0] in_ports = 0;
  logic [95:0] out_ports;
  logic [6:0] seg;
  logic [3:0] an;
  int checks = 0, errors = 0;

  pipe_io_bank #(.N_IN(2), .IN_W(4), .N_OUT(3), .N_HEX(4), .DB_CYC(16), .SCAN_DIV(SCAN)) dut (
    .clock(clock), .reset(reset), .sel(sel), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata),
    .in_ports(in_ports), .out_ports(out_ports), .seg(seg), .an(an), .irq(irq)
  );

  always #10 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    sel = 1; we = 0; addr = a;
    #1;
    chk(tag, rdata, exp);
    sel = 0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    sel = 1; we = 1; addr = a; wdata = d;
    tick();
    sel = 0; we = 0;
  endtask

  task automatic sync_an(input logic [3:0] v);
    int n;
    logic [3:0] prev;
    n = 0;
    prev = an;
    tick();
    while (!(an == v && prev != v) && n < 200) begin
      prev = an;
      tick();
      n++;
    end
    chk("scan_sync", 32'(n < 200), 1);
  endtask

  initial begin
    tick(3);
    rd_chk("rst_in0", 8'h00, 0);
    rd_chk("rst_out0", 8'h40, 0);
    rd_chk("rst_status", 8'h80, 0);
    rd_chk("rst_hexctl", 8'h84, 32'hF);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_irq", 32'(irq), 0);
    reset = 0;
    tick();
    sel = 1; we = 1; addr = 8'h40; wdata = 32'h0000_1234;
    #1;
    chk("same_cycle_read", rdata, 0);
    tick();
    sel = 0; we = 0;
    chk("out0_port", out_ports[31:0], 32'h1234);
    rd_chk("out0_read", 8'h40, 32'h1234);
    wr(8'h48, 32'hCAFE_F00D);
    chk("out2_port", out_ports[95:64], 32'hCAFE_F00D);
    chk("out1_port", out_ports[63:32], 0);
    sync_an(4'hE);
    chk("scan0_an", 32'(an), 32'hE);
    chk("scan0_seg", 32'(seg), 32'h19);
    tick(SCAN);
    chk("scan1_an", 32'(an), 32'hD);
    chk("scan1_seg", 32'(seg), 32'h30);
    tick(SCAN);
    chk("scan2_an", 32'(an), 32'hB);
    chk("scan2_seg", 32'(seg), 32'h24);
    tick(SCAN);
    chk("scan3_an", 32'(an), 32'h7);
    chk("scan3_seg", 32'(seg), 32'h79);
    in_ports[3:0] = 4'h5;
    tick(17);
    rd_chk("db_early", 8'h00, 0);
    chk("status_early", 32'(dut.status_q), 0);
    tick();
    rd_chk("db_18", 8'h00, 5);
    rd_chk("status_set", 8'h80, 1);
    chk("irq_lag", 32'(irq), 0);
    tick();
    chk("irq_set", 32'(irq), 1);
    wr(8'h80, 32'h1);
    rd_chk("status_clr", 8'h80, 0);
    tick();
    chk("irq_clr", 32'(irq), 0);
    in_ports[3:0] = 4'hA;
    tick(10);
    in_ports[3:0] = 4'h5;
    tick(30);
    rd_chk("glitch_in0", 8'h00, 5);
    rd_chk("glitch_status", 8'h80, 0);
    in_ports = 8'h36;
    tick(18);
    rd_chk("both_in0", 8'h00, 6);
    rd_chk("both_in1", 8'h04, 3);
    rd_chk("both_status", 8'h80, 3);
    tick();
    chk("both_irq", 32'(irq), 1);
    wr(8'h80, 32'h1);
    rd_chk("w1c_bit0", 8'h80, 2);
    tick();
    chk("irq_hold", 32'(irq), 1);
    in_ports[7:4] = 4'h9;
    tick(17);
    wr(8'h80, 32'h2);
    rd_chk("set_wins", 8'h80, 2);
    rd_chk("in1_upd", 8'h04, 9);
    wr(8'h84, 32'hFFFF_FFF5);
    rd_chk("hexctl_rd", 8'h84, 5);
    wr(8'h00, 32'hFFFF_FFFF);
    wr(8'hC0, 32'hFFFF_FFFF);
    rd_chk("ro_in0", 8'h00, 6);
    rd_chk("unmapped", 8'hC0, 0);
    rd_chk("ro_out0", 8'h40, 32'h1234);
    rd_chk("ro_hexctl", 8'h84, 5);
    chk("ro_ports", out_ports[63:0], 64'h0000_0000_0000_1234);
    sync_an(4'hE);
    chk("mask0_seg", 32'(seg), 32'h19);
    tick(SCAN);
    chk("mask1_an", 32'(an), 32'hF);
    chk("mask1_seg", 32'(seg), 32'h7F);
    tick(SCAN);
    chk("mask2_an", 32'(an), 32'hB);
    chk("mask2_seg", 32'(seg), 32'h24);
    tick(SCAN);
    chk("mask3_an", 32'(an), 32'hF);
    tick(SCAN / 2);
    in_ports[3:0] = 4'hC;
    tick(12);
    reset = 1;
    tick();
    rd_chk("mid_in0", 8'h00, 0);
    rd_chk("mid_status", 8'h80, 0);
    rd_chk("mid_hexctl", 8'h84, 32'hF);
    chk("mid_ports", out_ports[31:0], 0);
    chk("mid_an", 32'(an), 32'hF);
    chk("mid_seg", 32'(seg), 32'h7F);
    chk("mid_irq", 32'(irq), 0);
    reset = 0;
    tick(17);
    rd_chk("post_rst_early", 8'h00, 0);
    tick();
    rd_chk("post_rst_18", 8'h00, 32'hC);
    rd_chk("nosel", 8'h00, 32'hC);
    sel = 0; addr = 8'h00;
    #1;
    chk("sel_low", rdata, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
